// File: rtl/fmap_out_packer_pkg.sv
// Shared definitions for the output-side pixel stream blocks: pixel/word
// geometry and the frame capture state encoding.
package fmap_out_packer_pkg;

   localparam int PIX_W  = 8;
   localparam int WORD_W = 32;
   localparam int LANES  = 4;
   localparam int LANE_W = $clog2(LANES);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COLLECT = 2'd1,
      FLUSH   = 2'd2,
      DONE    = 2'd3
   } state_t;

endpackage

// File: rtl/fmap_out_packer_byte_lane_packer.sv
// Byte lane packer: gathers pixels into a staging word and emits a registered
// word write when the last lane fills, or a partial word on flush.
module fmap_out_packer_byte_lane_packer
   import fmap_out_packer_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              clear,
   input  logic              push,
   input  logic              flush,
   input  logic [PIX_W-1:0]  pix,
   output logic              word_last,
   output logic              wr_en,
   output logic [WORD_W-1:0] wr_data,
   output logic [LANES-1:0]  wr_be
);

   logic [LANE_W-1:0] lane_cnt_reg;
   logic [WORD_W-1:0] stage_word;
   logic [LANES-1:0]  fill_mask;
   logic              lane_reset;

   // The next accepted pixel lands in the top lane and completes the word.
   assign word_last  = (lane_cnt_reg == LANE_W'(LANES - 1));
   assign lane_reset = clear || flush || (push && word_last);

   // Only the lower lanes need staging; the top lane goes straight into the
   // write word, so a new word can start filling while the previous is written.
   genvar gi;
   generate
      for (gi = 0; gi < LANES - 1; gi++) begin : g_lane
         logic [PIX_W-1:0] lane_reg;

         // Capture the pixel addressed by the lane counter; empty after each word.
         always_ff @(posedge clk) begin
            if (rst || lane_reset) begin
               lane_reg <= '0;
            end else if (push && (lane_cnt_reg == LANE_W'(gi))) begin
               lane_reg <= pix;
            end
         end

         assign stage_word[gi*PIX_W +: PIX_W] = lane_reg;
         assign fill_mask[gi] = (LANE_W'(gi) < lane_cnt_reg);
      end
   endgenerate

   assign stage_word[WORD_W-1 -: PIX_W] = '0;
   assign fill_mask[LANES-1]            = 1'b0;

   // Lane counter and the registered write word / strobe / byte enables.
   always_ff @(posedge clk) begin
      if (rst) begin
         lane_cnt_reg <= '0;
         wr_en        <= 1'b0;
         wr_data      <= '0;
         wr_be        <= '0;
      end else begin
         wr_en <= 1'b0;
         wr_be <= '0;
         if (clear) begin
            lane_cnt_reg <= '0;
         end else if (flush) begin
            wr_en        <= 1'b1;
            wr_data      <= stage_word;
            wr_be        <= fill_mask;
            lane_cnt_reg <= '0;
         end else if (push) begin
            if (word_last) begin
               wr_en        <= 1'b1;
               wr_data      <= {pix, stage_word[WORD_W-PIX_W-1:0]};
               wr_be        <= '1;
               lane_cnt_reg <= '0;
            end else begin
               lane_cnt_reg <= lane_cnt_reg + 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/fmap_out_packer.sv
// Output feature-map packer: captures one frame of int8 pixels, tracks the
// column/row position and word address, and writes packed words to RAM.
module fmap_out_packer
   import fmap_out_packer_pkg::*;
#(
   parameter int OUT_W  = 10,
   parameter int OUT_H  = 12,
   parameter int ADDR_W = 8
)(
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic              valid_in,
   input  logic [PIX_W-1:0]  din,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [WORD_W-1:0] wr_data,
   output logic [LANES-1:0]  wr_be,
   output logic              busy,
   output logic              frame_done,
   output logic              stray_err
);

   localparam int COL_W = (OUT_W > 1) ? $clog2(OUT_W) : 1;
   localparam int ROW_W = (OUT_H > 1) ? $clog2(OUT_H) : 1;
   localparam logic [COL_W-1:0] COL_LAST = COL_W'(OUT_W - 1);
   localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(OUT_H - 1);

   state_t            state_reg;
   logic [COL_W-1:0]  col_reg;
   logic [ROW_W-1:0]  row_reg;
   logic [ADDR_W-1:0] addr_reg;
   logic              push;
   logic              flush;
   logic              clear;
   logic              word_last;
   logic              last_pix;
   logic              writing;

   assign push     = (state_reg == COLLECT) && valid_in;
   assign flush    = (state_reg == FLUSH);
   assign clear    = (state_reg == IDLE) && start;
   assign last_pix = (col_reg == COL_LAST) && (row_reg == ROW_LAST);
   // A word write is issued on this edge and appears on wr_en next cycle.
   assign writing  = (push && word_last) || flush;

   fmap_out_packer_byte_lane_packer u_lanes (
      .clk       (clk),
      .rst       (rst),
      .clear     (clear),
      .push      (push),
      .flush     (flush),
      .pix       (din),
      .word_last (word_last),
      .wr_en     (wr_en),
      .wr_data   (wr_data),
      .wr_be     (wr_be)
   );

   // Frame FSM with position/address counters and registered status outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg  <= IDLE;
         col_reg    <= '0;
         row_reg    <= '0;
         addr_reg   <= '0;
         wr_addr    <= '0;
         busy       <= 1'b0;
         frame_done <= 1'b0;
         stray_err  <= 1'b0;
      end else begin
         frame_done <= 1'b0;
         if (writing) begin
            wr_addr  <= addr_reg;
            addr_reg <= addr_reg + 1'b1;
         end
         case (state_reg)
            IDLE: begin
               if (valid_in) begin
                  stray_err <= 1'b1;
               end
               // start wins over a same-cycle stray pixel
               if (start) begin
                  addr_reg  <= base_addr;
                  col_reg   <= '0;
                  row_reg   <= '0;
                  stray_err <= 1'b0;
                  busy      <= 1'b1;
                  state_reg <= COLLECT;
               end
            end
            COLLECT: begin
               if (valid_in) begin
                  if (col_reg == COL_LAST) begin
                     col_reg <= '0;
                     row_reg <= row_reg + 1'b1;
                  end else begin
                     col_reg <= col_reg + 1'b1;
                  end
                  if (last_pix) begin
                     row_reg   <= '0;
                     state_reg <= word_last ? DONE : FLUSH;
                  end
               end
            end
            FLUSH: begin
               if (valid_in) begin
                  stray_err <= 1'b1;
               end
               state_reg <= DONE;
            end
            DONE: begin
               if (valid_in) begin
                  stray_err <= 1'b1;
               end
               frame_done <= 1'b1;
               busy       <= 1'b0;
               state_reg  <= IDLE;
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_fmap_out_packer.sv
// Randomized bench for fmap_out_packer: a 10x12 and a 5x3 instance, checked
// against a frame-level model that packs accepted pixels into expected writes.
module tb_fmap_out_packer;

   typedef struct {
      int          inst;
      int          kind;    // 0 = word write, 1 = frame_done
      int          stamp;   // clock edge after which the event is visible
      logic [7:0]  addr;
      logic [31:0] data;
      logic [3:0]  be;
   } ev_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic [1:0]       rst_s, start_s, valid_s;
   logic [1:0][7:0]  base_s, din_s;
   logic [1:0]       wr_en_o, busy_o, fd_o, stray_o;
   logic [1:0][7:0]  wr_addr_o;
   logic [1:0][31:0] wr_data_o;
   logic [1:0][3:0]  wr_be_o;

   fmap_out_packer #(.OUT_W(10), .OUT_H(12), .ADDR_W(8)) u_dut_a (
      .clk(clk), .rst(rst_s[0]), .start(start_s[0]), .base_addr(base_s[0]),
      .valid_in(valid_s[0]), .din(din_s[0]), .wr_en(wr_en_o[0]),
      .wr_addr(wr_addr_o[0]), .wr_data(wr_data_o[0]), .wr_be(wr_be_o[0]),
      .busy(busy_o[0]), .frame_done(fd_o[0]), .stray_err(stray_o[0]));

   fmap_out_packer #(.OUT_W(5), .OUT_H(3), .ADDR_W(8)) u_dut_b (
      .clk(clk), .rst(rst_s[1]), .start(start_s[1]), .base_addr(base_s[1]),
      .valid_in(valid_s[1]), .din(din_s[1]), .wr_en(wr_en_o[1]),
      .wr_addr(wr_addr_o[1]), .wr_data(wr_data_o[1]), .wr_be(wr_be_o[1]),
      .busy(busy_o[1]), .frame_done(fd_o[1]), .stray_err(stray_o[1]));

   int n_chk = 0;
   int n_fail = 0;
   int ed = 0;

   // reference model state, per instance
   int          total [2] = '{120, 15};
   bit          armed [2] = '{0, 0};
   int          cnt   [2] = '{0, 0};
   int          fd_st [2] = '{0, 0};
   int          nacc  [2] = '{0, 0};
   logic [31:0] acc   [2] = '{0, 0};
   logic [7:0]  addr_m[2] = '{0, 0};
   bit          stray_m[2] = '{0, 0};

   ev_t exp_q[$];
   ev_t obs_q[$];
   logic [7:0] pix_buf [120];

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (edge %0d)", tag, got, exp, ed);
      end
   endtask

   // Frame-level model: accepted pixels pack in arrival order, four per word.
   task automatic model_edge(input int i, input bit s, input bit v,
                             input logic [7:0] d, input bit r, input logic [7:0] b);
      logic [3:0] be;
      if (r) begin
         armed[i] = 0; cnt[i] = 0; nacc[i] = 0; acc[i] = '0;
         fd_st[i] = 0; stray_m[i] = 0;
         return;
      end
      if (v) begin
         if (armed[i]) begin
            acc[i] = acc[i] | (32'(d) << (8 * nacc[i]));
            nacc[i]++;
            cnt[i]++;
            if (nacc[i] == 4) begin
               exp_q.push_back('{i, 0, ed, addr_m[i], acc[i], 4'hF});
               addr_m[i] = addr_m[i] + 8'd1;
               acc[i] = '0; nacc[i] = 0;
            end
            if (cnt[i] == total[i]) begin
               armed[i] = 0;
               if (nacc[i] != 0) begin
                  be = 4'((1 << nacc[i]) - 1);
                  exp_q.push_back('{i, 0, ed + 1, addr_m[i], acc[i], be});
                  addr_m[i] = addr_m[i] + 8'd1;
                  fd_st[i] = ed + 2;
               end else begin
                  fd_st[i] = ed + 1;
               end
               exp_q.push_back('{i, 1, fd_st[i], 8'h00, 32'h0, 4'h0});
               acc[i] = '0; nacc[i] = 0;
            end
         end else begin
            stray_m[i] = 1;
         end
      end
      if (s && !armed[i] && ed > fd_st[i]) begin
         armed[i] = 1; cnt[i] = 0; addr_m[i] = b;
         stray_m[i] = 0; fd_st[i] = 32'h7fff_ffff;
      end
   endtask

   // Record every write and frame_done seen on either instance.
   always @(negedge clk) begin
      for (int i = 0; i < 2; i++) begin
         if (wr_en_o[i] === 1'b1)
            obs_q.push_back('{i, 0, ed, wr_addr_o[i], wr_data_o[i], wr_be_o[i]});
         if (fd_o[i] === 1'b1)
            obs_q.push_back('{i, 1, ed, 8'h00, 32'h0, 4'h0});
      end
   end

   task automatic step(input int i, input bit s, input bit v, input logic [7:0] d,
                       input bit r, input logic [7:0] b);
      start_s = '0; valid_s = '0; rst_s = '0; din_s = '0;
      start_s[i] = s; valid_s[i] = v; din_s[i] = d; rst_s[i] = r; base_s[i] = b;
      @(posedge clk);
      ed++;
      for (int j = 0; j < 2; j++) begin
         if (j == i) model_edge(j, s, v, d, r, b);
         else        model_edge(j, 0, 0, 8'h00, 0, 8'h00);
      end
      #1;
      for (int j = 0; j < 2; j++) begin
         check_eq("busy", busy_o[j], (ed < fd_st[j]));
         check_eq("stray_err", stray_o[j], stray_m[j]);
      end
   endtask

   task automatic reset_both();
      start_s = '0; valid_s = '0; din_s = '0; base_s = '0; rst_s = '1;
      repeat (2) begin
         @(posedge clk);
         ed++;
         model_edge(0, 0, 0, 8'h00, 1, 8'h00);
         model_edge(1, 0, 0, 8'h00, 1, 8'h00);
      end
      rst_s = '0;
      #1;
   endtask

   task automatic check_outputs_zero(input int j);
      check_eq("rst_wr_en", wr_en_o[j], 0);
      check_eq("rst_wr_addr", wr_addr_o[j], 0);
      check_eq("rst_wr_data", wr_data_o[j], 0);
      check_eq("rst_wr_be", wr_be_o[j], 0);
      check_eq("rst_busy", busy_o[j], 0);
      check_eq("rst_frame_done", fd_o[j], 0);
      check_eq("rst_stray_err", stray_o[j], 0);
   endtask

   // gap: 0 back-to-back, 1 alternate idle cycles, 2 random idle cycles
   task automatic run_frame(input int i, input logic [7:0] b, input int gap, input int mid_start);
      step(i, 1, 0, 8'h00, 0, b);
      for (int k = 0; k < total[i]; k++) begin
         if (gap == 1 && k > 0) step(i, 0, 0, 8'h00, 0, b);
         if (gap == 2) repeat ($urandom_range(0, 2)) step(i, 0, 0, 8'h00, 0, b);
         step(i, (k == mid_start), 1, pix_buf[k], 0, b);
      end
      repeat (4) step(i, 0, 0, 8'h00, 0, b);
   endtask

   task automatic compare_events(input string tag);
      int n;
      check_eq({tag, "_count"}, obs_q.size(), exp_q.size());
      n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
      for (int k = 0; k < n; k++) begin
         check_eq({tag, "_kind"}, obs_q[k].kind + 2 * obs_q[k].inst, exp_q[k].kind + 2 * exp_q[k].inst);
         check_eq({tag, "_stamp"}, obs_q[k].stamp, exp_q[k].stamp);
         check_eq({tag, "_addr"}, obs_q[k].addr, exp_q[k].addr);
         check_eq({tag, "_data"}, obs_q[k].data, exp_q[k].data);
         check_eq({tag, "_be"}, obs_q[k].be, exp_q[k].be);
      end
      obs_q.delete();
      exp_q.delete();
   endtask

   task automatic fill_random();
      for (int k = 0; k < 120; k++) pix_buf[k] = 8'($urandom);
   endtask

   initial begin
      reset_both();
      check_outputs_zero(0);
      check_outputs_zero(1);

      // full frame, back-to-back, din = 1..10 repeating
      for (int k = 0; k < 120; k++) pix_buf[k] = 8'((k % 10) + 1);
      run_frame(0, 8'h10, 0, -1);
      check_eq("full_events", obs_q.size(), 31);
      if (obs_q.size() >= 31) begin
         check_eq("full_word0", obs_q[0].data, 32'h04030201);
         check_eq("full_word1", obs_q[1].data, 32'h08070605);
         check_eq("full_word2", obs_q[2].data, 32'h02010A09);
         check_eq("full_first_addr", obs_q[0].addr, 8'h10);
         check_eq("full_last_addr", obs_q[29].addr, 8'h2D);
         check_eq("full_done_gap", obs_q[30].stamp - obs_q[29].stamp, 1);
      end
      compare_events("full");

      // partial flush on the 5x3 instance
      for (int k = 0; k < 15; k++) pix_buf[k] = 8'(k + 1);
      run_frame(1, 8'h00, 0, -1);
      check_eq("flush_events", obs_q.size(), 5);
      if (obs_q.size() >= 5) begin
         check_eq("flush_addr", obs_q[3].addr, 8'h03);
         check_eq("flush_data", obs_q[3].data, 32'h000F0E0D);
         check_eq("flush_be", obs_q[3].be, 4'b0111);
         check_eq("flush_done", obs_q[4].kind, 1);
      end
      compare_events("flush");

      // gapped input, same data as the back-to-back frame
      for (int k = 0; k < 120; k++) pix_buf[k] = 8'((k % 10) + 1);
      run_frame(0, 8'h10, 1, -1);
      compare_events("gapped");

      // signed values stored bit-exact
      fill_random();
      pix_buf[0] = 8'hFF; pix_buf[1] = 8'h80; pix_buf[2] = 8'h7F; pix_buf[3] = 8'h00;
      run_frame(0, 8'h00, 2, -1);
      if (obs_q.size() > 0) check_eq("neg_word0", obs_q[0].data, 32'h007F80FF);
      compare_events("neg");

      // stray pixels in IDLE, then a frame with start pulsed mid-frame and wrap
      for (int k = 0; k < 3; k++) step(0, 0, 1, 8'($urandom), 0, 8'h00);
      check_eq("stray_idle", stray_o[0], 1);
      compare_events("stray");
      fill_random();
      run_frame(0, 8'hF0, 2, 50);
      for (int k = 0; k < 2; k++) step(0, 0, 1, 8'($urandom), 0, 8'h00);
      compare_events("restart");

      // start and pixel in the same idle cycle: pixel dropped, flag cleared
      step(1, 0, 1, 8'h5A, 0, 8'h00);
      step(1, 1, 1, 8'hAA, 0, 8'h40);
      check_eq("start_clears_stray", stray_o[1], 0);
      fill_random();
      for (int k = 0; k < 15; k++) begin
         if ($urandom_range(0, 1) == 1) step(1, 0, 0, 8'h00, 0, 8'h40);
         step(1, 0, 1, pix_buf[k], 0, 8'h40);
      end
      repeat (4) step(1, 0, 0, 8'h00, 0, 8'h40);
      compare_events("same_cycle");

      // reset mid-frame after six pixels, then restart at a new base
      fill_random();
      step(0, 1, 0, 8'h00, 0, 8'h20);
      for (int k = 0; k < 6; k++) step(0, 0, 1, pix_buf[k], 0, 8'h20);
      step(0, 0, 0, 8'h00, 1, 8'h20);
      check_outputs_zero(0);
      repeat (5) step(0, 0, 0, 8'h00, 0, 8'h20);
      check_eq("rst_writes", obs_q.size(), 1);
      compare_events("rst_mid");
      fill_random();
      run_frame(0, 8'h80, 2, -1);
      if (obs_q.size() > 0) check_eq("rst_new_base", obs_q[0].addr, 8'h80);
      compare_events("after_rst");

      // a few more randomized frames on both instances
      for (int f = 0; f < 3; f++) begin
         fill_random();
         run_frame(f % 2, 8'($urandom), 2, -1);
         compare_events("rand");
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/fmap_out_packer.md
Name: fmap_out_packer

Overview:
- Sink at the output end of the conv_1X3X3 pixel stream: accepts the signed int8 stream (valid_out/dout of the conv stage) for one output feature map.
- Counts columns and rows, packs four consecutive pixels into 32-bit little-endian words, and issues word writes to the output feature-map RAM.
- Signals frame completion to the layer controller; the controller re-arms the block per frame.

Parameters:
- OUT_W, 10, output feature-map width in pixels (>=1)
- OUT_H, 12, output feature-map height in pixels (>=1)
- ADDR_W, 8, word address width; must satisfy 2**ADDR_W >= ceil(OUT_W*OUT_H/4)

Ports:
- clk  input  1  system clock; all logic on rising edge
- rst  input  1  synchronous reset, active-high
- start  input  1  one-cycle pulse arming capture of one frame; base address sampled here
- base_addr  input  ADDR_W  first word address of the frame
- valid_in  input  1  pixel strobe, driven by conv valid_out
- din  input  8  signed pixel, driven by conv dout
- wr_en  output  1  RAM write strobe
- wr_addr  output  ADDR_W  RAM word address
- wr_data  output  32  packed pixels; byte k = k-th pixel of the word
- wr_be  output  4  byte enables
- busy  output  1  high from the cycle after start until frame_done
- frame_done  output  1  one-cycle pulse after the last word is written
- stray_err  output  1  sticky flag: valid_in seen while not armed; cleared by start or rst

Behaviour:
- Reset: all outputs 0; state IDLE; column, row and lane counters 0; packing register 0.
- States: IDLE, COLLECT, FLUSH, DONE.
- IDLE + start: latch base_addr into the address counter, clear the counters, clear stray_err, enter COLLECT. busy rises the next cycle.
- COLLECT, valid_in=1:
  - write din into lane[lane_cnt]; increment lane_cnt modulo 4.
  - col increments; at col==OUT_W-1, col wraps to 0 and row increments.
- COLLECT, lane full: when the 4th byte is accepted, the next cycle drives wr_en=1, wr_be=4'b1111, wr_data=the packed word, and wr_addr=the current address. The address then increments. Latency from the 4th valid_in to wr_en is 1 cycle.
- Continuous input: valid_in on consecutive cycles must be sustainable with no stall and no pixel loss. The packing register is double-buffered (staging word + write word). There is no backpressure port: the conv stage cannot be stalled.
- Last pixel: when the pixel at row==OUT_H-1, col==OUT_W-1 is accepted:
  - if its lane completes a word, the write happens as normal, then DONE;
  - otherwise enter FLUSH. FLUSH writes the partial word with wr_be bits set for filled lanes only; unfilled lanes of wr_data are 0.
- DONE: frame_done=1 for exactly one cycle, busy falls in the same cycle, then IDLE.
- Extra pixels: valid_in in FLUSH, DONE or IDLE is dropped and sets stray_err. No write occurs.
- Packing across row boundaries: pixels pack across rows with no per-row alignment. Word count = ceil(OUT_W*OUT_H/4).
- start while busy: ignored; the frame in progress is unaffected.
- start and valid_in in the same IDLE cycle: the pixel is dropped (stray_err set), then cleared by the start in the same cycle. Net result: stray_err=0 and the pixel is not captured.
- Address wrap: wr_addr wraps modulo 2**ADDR_W with no error.
- rst mid-frame: immediate return to the reset state. The partial word is discarded, and no wr_en or frame_done is issued.
- Signedness: din is stored bit-exact. There is no sign extension, saturation, or arithmetic in the datapath.

Decomposition:
- Shared package (layer-wide, reused by the other stream blocks): pixel width constant PIX_W=8, WORD_W=32, LANES=4, and the state enum (IDLE, COLLECT, FLUSH, DONE).
- One sub-module, byte_lane_packer: lane counter, staging/write registers, byte-enable generation, flush. The top level holds the col/row/address counters and the FSM.

Test Plan:
- Full frame, defaults: start with base_addr=0x10, then 120 back-to-back pixels with din = 1..10 repeating.
  - Expect 30 writes at addr 0x10..0x2D, all wr_be=1111.
  - First wr_data=0x04030201; second=0x08070605; third=0x02010A09.
  - frame_done one cycle after the 30th write; stray_err=0.
- Partial flush, OUT_W=5, OUT_H=3: 15 pixels (0x01..0x0F), base 0.
  - 3 full words, then a 4th write at addr 3 with wr_data=0x000F0E0D, wr_be=0111.
  - frame_done follows.
- Gapped input: valid_in toggled 1-0-1-0 over a full frame. Expect the same write data and addresses as the back-to-back case, each wr_en exactly 1 cycle after the 4th accepted pixel.
- Negative values: pixels -1, -128, 127, 0. Expect wr_data=0x007F80FF.
- Stray and restart:
  - 3 pixels in IDLE: no wr_en, stray_err=1.
  - start: stray_err=0.
  - Frame capture is then normal.
  - start pulsed mid-frame: ignored; addresses continue.
- Reset mid-frame: rst after 6 pixels (1 word written). Expect no further wr_en and no frame_done, and all outputs 0. A new start then restarts at the new base_addr with lane 0.
